pci_cmd_ctrl: RTL and testbench
===============================

// Module: pci_cmd_ctrl
// PURPOSE
//  PCI target command/handshake controller.
//  - Samples C/BE# in the address phase and classifies the bus command as read, write or none.
//  - Tracks transaction phases from FRAME#/IRDY#.
//  - Drives the read/write enables consumed by the target storage block.
//  - Sits between the pin-level PCI signals and the address decoder / storage / TRDY logic of the target.
// PARAMETERS
//  RD_CMD   4'b0110  memory-read command code (also accepted: 4'b1100, 4'b1110)
//  WR_CMD   4'b0111  memory-write command code (also accepted: 4'b1111)
// PORTS
//  Clock    in   1  single system clock; all state updates on its rising edge
//  RST      in   1  reset, synchronous, active-high
//  Frame    in   1  PCI FRAME#, active-low
//  CBE      in   4  PCI C/BE#: command in address phase, byte enables in data phase
//  Irdy     in   1  PCI IRDY#, active-low
//  Devsel   in   1  DEVSEL# from target device-select logic, active-low
//  rw       out  2  latched command: 2'b01 read, 2'b10 write, 2'b00 none; 2'b11 never driven
//  RE       out  1  read enable, active-high
//  WE       out  1  write enable, active-high
//  addr_ph  out  1  one-cycle pulse on the cycle the address/command is latched
//  busy     out  1  high while a transaction is in progress (state != IDLE)
// BEHAVIOUR
//  Reset: RST=1 at a rising edge -> state=IDLE, rw=00; hence RE=WE=addr_ph=busy=0. RST overrides every other input.
//  States:
//   IDLE -> ADDR: on an edge with Frame=0; on this edge rw <= decode(CBE).
//   ADDR -> DATA: unconditionally on the next edge.
//   DATA -> DATA: while Frame=0.
//   DATA -> IDLE: on an edge with Frame=1 and Irdy=0 (final beat), or with Frame=1 and Irdy=1 (master gone). rw <= 00 on this edge.
//  decode(CBE): 0110/1100/1110 -> 01; 0111/1111 -> 10; any other code -> 00. A 00 transaction still walks ADDR/DATA but never asserts RE or WE.
//  addr_ph = (state==ADDR).
//  RE = (state==DATA) & (rw==01) & ~Devsel & ~Irdy   (combinational).
//  WE = (state==DATA) & (rw==10) & ~Devsel & ~Irdy   (combinational).
//  Latency: command on CBE at edge N -> rw valid after edge N; the first RE/WE can assert after edge N+1.
//  During DATA, CBE is byte enables: it never alters rw.
//  Frame=0 held continuously after a return to IDLE: starts a new ADDR on the next edge (back-to-back transaction, no idle cycle needed).
//  Devsel=1 or Irdy=1 in DATA: wait state; RE=WE=0 and state/rw hold.
//  X/Z on Frame or Irdy while in IDLE: treated as idle (no transition).
//  RST asserted mid-transaction: abort immediately to IDLE; the next transaction needs a fresh Frame=0 edge.
// STRUCTURE
//  Shared package pci_pkg:
//   - command-code localparams;
//   - rw encoding constants RW_NONE/RW_READ/RW_WRITE;
//   - state enum {IDLE, ADDR, DATA}.
//  Sub-modules:
//   - pci_cmd_decode: combinational CBE -> rw code.
//   - pci_clock_gen: simulation-only, free-running, 10-time-unit period, starts at 0, not synthesised.
// TESTING (pci_clock_gen drives Clock; rising edges at t=5,15,25...)
//  1. RST=1 for 2 edges with Frame=0, CBE=7 -> rw=00, RE=WE=busy=0 throughout.
//  2. Write burst: Frame=0, CBE=7 at t=10; Irdy=0, Devsel=0 from t=20; Frame=1 at t=60; Irdy=1 at t=70
//     -> rw=10 from t=15; WE=1 during t=25..65; state IDLE and rw=00 after the t=65 edge.
//  3. Read burst: same timing with CBE=6 -> rw=01, RE=1 for 4 beats, WE=0 always.
//  4. Wait states: the write burst of test 2 with Devsel=1 for one data cycle -> WE=0 that cycle; rw and state hold.
//  5. Unsupported command CBE=4'b0010 -> rw=00, RE=WE=0 for the whole transaction; busy still asserts.
//  6. Back-to-back: write then read with Frame=0 re-asserted the cycle after the final beat
//     -> addr_ph pulses twice; rw goes 10 -> 00 -> 01.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI target command controller: command codes,
// rw encoding, transaction phase enum and the command classifier.
package pci_pkg;

   localparam logic [3:0] CMD_MEM_READ      = 4'b0110;
   localparam logic [3:0] CMD_MEM_READ_MULT = 4'b1100;
   localparam logic [3:0] CMD_MEM_READ_LINE = 4'b1110;
   localparam logic [3:0] CMD_MEM_WRITE     = 4'b0111;
   localparam logic [3:0] CMD_MEM_WRITE_INV = 4'b1111;

   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   // Classify a C/BE# command code; the primary read/write codes are configurable.
   function automatic logic [1:0] decode_cmd(input logic [3:0] cmd,
                                             input logic [3:0] rd_cmd,
                                             input logic [3:0] wr_cmd);
      logic [1:0] res;
      if ((cmd == rd_cmd) || (cmd == CMD_MEM_READ_MULT) || (cmd == CMD_MEM_READ_LINE)) begin
         res = RW_READ;
      end else if ((cmd == wr_cmd) || (cmd == CMD_MEM_WRITE_INV)) begin
         res = RW_WRITE;
      end else begin
         res = RW_NONE;
      end
      return res;
   endfunction

endpackage

// File: rtl/pci_cmd_decode.sv
// Combinational C/BE# command classifier: maps the address-phase command code
// onto the read/write/none rw encoding.
import pci_pkg::*;

module pci_cmd_decode #(
   parameter logic [3:0] RD_CMD = CMD_MEM_READ,
   parameter logic [3:0] WR_CMD = CMD_MEM_WRITE
) (
   input  logic [3:0] cbe,
   output logic [1:0] rw
);

   // Pure decode of the command code presented on C/BE#.
   always_comb begin
      rw = decode_cmd(cbe, RD_CMD, WR_CMD);
   end

endmodule

// File: rtl/pci_cmd_ctrl.sv
// PCI target command/handshake controller: latches the bus command in the
// address phase, tracks IDLE/ADDR/DATA phases and drives storage enables.
import pci_pkg::*;

module pci_cmd_ctrl #(
   parameter logic [3:0] RD_CMD = CMD_MEM_READ,
   parameter logic [3:0] WR_CMD = CMD_MEM_WRITE
) (
   input  logic       Clock,
   input  logic       RST,
   input  logic       Frame,
   input  logic [3:0] CBE,
   input  logic       Irdy,
   input  logic       Devsel,
   output logic [1:0] rw,
   output logic       RE,
   output logic       WE,
   output logic       addr_ph,
   output logic       busy
);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [1:0] rw_r;
   logic [1:0] rw_nxt_s;
   logic [1:0] cmd_rw_s;
   logic       beat_s;

   pci_cmd_decode #(
      .RD_CMD (RD_CMD),
      .WR_CMD (WR_CMD)
   ) u_decode (
      .cbe (CBE),
      .rw  (cmd_rw_s)
   );

   // Phase and command registers; RST aborts any transaction in flight.
   always_ff @(posedge Clock) begin
      if (RST) begin
         state_r <= IDLE;
         rw_r    <= RW_NONE;
      end else begin
         state_r <= state_nxt_s;
         rw_r    <= rw_nxt_s;
      end
   end

   // Next-phase logic. An unknown Frame in IDLE compares false and so
   // leaves the controller idle; C/BE# only matters on the IDLE->ADDR edge.
   always_comb begin
      state_nxt_s = state_r;
      rw_nxt_s    = rw_r;
      case (state_r)
         IDLE: begin
            if (Frame == 1'b0) begin
               state_nxt_s = ADDR;
               rw_nxt_s    = cmd_rw_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ADDR: begin
            state_nxt_s = DATA;
         end
         DATA: begin
            if (Frame == 1'b0) begin
               state_nxt_s = DATA;
            end else begin
               state_nxt_s = IDLE;
               rw_nxt_s    = RW_NONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            rw_nxt_s    = RW_NONE;
         end
      endcase
   end

   // A data beat completes only when both sides are ready in DATA.
   always_comb begin
      beat_s  = (state_r == DATA) && (Devsel == 1'b0) && (Irdy == 1'b0);
      RE      = beat_s && (rw_r == RW_READ);
      WE      = beat_s && (rw_r == RW_WRITE);
      addr_ph = (state_r == ADDR);
      busy    = (state_r != IDLE);
      rw      = rw_r;
   end

endmodule

// File: tb/tb_pci_cmd_ctrl.sv
// Scoreboard bench for pci_cmd_ctrl: directed bursts then randomized bus
// activity, checked cycle by cycle against a transaction-level model.
module tb_pci_cmd_ctrl;

   logic       Clock = 1'b0;
   logic       RST;
   logic       Frame;
   logic [3:0] CBE;
   logic       Irdy;
   logic       Devsel;
   logic [1:0] rw;
   logic       RE;
   logic       WE;
   logic       addr_ph;
   logic       busy;

   typedef struct packed {
      logic [1:0] rw;
      logic       re;
      logic       we;
      logic       addr_ph;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run = 0;
   int   fails     = 0;

   // Reference model: cycles spent in the current transaction (0 = no
   // transaction, 1 = address cycle, 2+ = data cycles) and the bus command.
   int         m_cycles = 0;
   logic [1:0] m_cmd    = 2'b00;

   pci_cmd_ctrl dut (
      .Clock   (Clock),
      .RST     (RST),
      .Frame   (Frame),
      .CBE     (CBE),
      .Irdy    (Irdy),
      .Devsel  (Devsel),
      .rw      (rw),
      .RE      (RE),
      .WE      (WE),
      .addr_ph (addr_ph),
      .busy    (busy)
   );

   always #5 Clock = ~Clock;

   function automatic logic [1:0] classify(input logic [3:0] c);
      if (c inside {4'b0110, 4'b1100, 4'b1110}) return 2'b01;
      if (c inside {4'b0111, 4'b1111}) return 2'b10;
      return 2'b00;
   endfunction

   // Drive one cycle of bus inputs, advance the model across the coming edge
   // and queue the outputs the DUT must show after that edge.
   task automatic drive(input logic rst, input logic frame, input logic [3:0] cbe,
                        input logic irdy, input logic devsel);
      exp_t e;
      @(negedge Clock);
      RST = rst; Frame = frame; CBE = cbe; Irdy = irdy; Devsel = devsel;
      if (rst) begin
         m_cycles = 0;
         m_cmd    = 2'b00;
      end else if (m_cycles == 0) begin
         if (frame == 1'b0) begin
            m_cycles = 1;
            m_cmd    = classify(cbe);
         end
      end else if (m_cycles == 1 || frame == 1'b0) begin
         m_cycles = 2;
      end else begin
         m_cycles = 0;
         m_cmd    = 2'b00;
      end
      e.rw      = m_cmd;
      e.addr_ph = (m_cycles == 1);
      e.busy    = (m_cycles != 0);
      e.re      = (m_cycles >= 2) && (m_cmd == 2'b01) && !devsel && !irdy;
      e.we      = (m_cycles >= 2) && (m_cmd == 2'b10) && !devsel && !irdy;
      exp_q.push_back(e);
   endtask

   // Address phase, four data beats (optional one-cycle DEVSEL# wait), final beat.
   task automatic burst(input logic [3:0] cmd, input int wait_beat);
      drive(1'b0, 1'b0, cmd, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, (i == wait_beat) ? 1'b1 : 1'b0);
      end
      drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
   endtask

   // Monitor: the DUT presents a result every cycle; compare just after the edge.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge Clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{rw: rw, re: RE, we: WE, addr_ph: addr_ph, busy: busy};
            tests_run++;
            if (a !== e) begin
               fails++;
               $display("FAIL cycle_check t=%0t got rw=%b RE=%b WE=%b addr_ph=%b busy=%b, expected rw=%b RE=%b WE=%b addr_ph=%b busy=%b",
                        $time, a.rw, a.re, a.we, a.addr_ph, a.busy,
                        e.rw, e.re, e.we, e.addr_ph, e.busy);
            end
         end
      end
   end

   initial begin
      logic [3:0] codes [8];
      int         wait_cnt;
      codes = '{4'b0110, 4'b1100, 4'b1110, 4'b0111, 4'b1111, 4'b0010, 4'b0000, 4'b1010};
      RST = 1'b1; Frame = 1'b0; CBE = 4'h7; Irdy = 1'b1; Devsel = 1'b1;

      // Reset held with an active write command on the bus.
      drive(1'b1, 1'b0, 4'h7, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 4'h7, 1'b1, 1'b1);
      idle_cycle();

      burst(4'h7, -1);         // write burst
      idle_cycle();
      burst(4'h6, -1);         // read burst
      idle_cycle();
      burst(4'h7, 1);          // write burst with a wait state
      idle_cycle();
      burst(4'b0010, -1);      // unsupported command
      idle_cycle();
      burst(4'h7, -1);         // back-to-back write then read
      burst(4'h6, -1);
      idle_cycle();

      // Abort mid-transaction, then a fresh transaction.
      drive(1'b0, 1'b0, 4'hF, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'hE, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
      idle_cycle();

      // Randomized bus activity biased toward real transactions.
      for (int n = 0; n < 1500; n++) begin
         drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1,
               ($urandom_range(0, 1) == 1) ? codes[$urandom_range(0, 7)] : 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
      end
      idle_cycle();

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge Clock);
         wait_cnt++;
      end
      #2;
      if (exp_q.size() > 0) begin
         fails++;
         $display("FAIL drain got %0d pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
